scan_point_sequencer: RTL

SCAN_POINT_SEQUENCER -- requirements
Module: scan_point_sequencer

---
 rtl/scan_point_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/scan_point_sequencer.sv
// rtl/scan_point_sequencer.sv - walks a depth x angle grid of scan points, handshaking each point's term results downstream
module scan_point_sequencer #(
    parameter int DW_INPUT     = 8,
    parameter int DW_ANGLE     = 8,
    parameter int DW_INTEGER   = 18,
    parameter int DW_FRACTION  = 6,
    parameter int NUM_ELEMENTS = 64
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   abort,
    input  logic [DW_INPUT+3:0]                    cfg_r0_start,
    input  logic [DW_INPUT+3:0]                    cfg_r0_step,
    input  logic [7:0]                             cfg_num_depths,
    input  logic [DW_ANGLE-1:0]                    cfg_angle_start,
    input  logic [DW_ANGLE-1:0]                    cfg_angle_step,
    input  logic [7:0]                             cfg_num_angles,
    output logic                                   calc_initiate,
    output logic                                   calc_ack,
    output logic [DW_INPUT+3:0]                    calc_r0,
    output logic [DW_ANGLE-1:0]                    calc_angle,
    input  logic signed [DW_INTEGER+DW_FRACTION-1:0] calc_term_pos,
    input  logic signed [DW_INTEGER+DW_FRACTION-1:0] calc_term_neg,
    input  logic                                   calc_last_element,
    input  logic                                   calc_ready,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic signed [DW_INTEGER+DW_FRACTION-1:0] out_term_pos,
    output logic signed [DW_INTEGER+DW_FRACTION-1:0] out_term_neg,
    output logic [$clog2(NUM_ELEMENTS/2)-1:0]      out_element,
    output logic [7:0]                             out_angle_idx,
    output logic [7:0]                             out_depth_idx,
    output logic                                   out_last_point,
    output logic                                   busy,
    output logic                                   done
);

    localparam int RW    = DW_INPUT + 4;
    localparam int NPAIR = NUM_ELEMENTS / 2;
    localparam int EW    = $clog2(NPAIR);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE    = 3'd1;
    localparam logic [2:0] S_WAIT_RES = 3'd2;
    localparam logic [2:0] S_ACK      = 3'd3;
    localparam logic [2:0] S_PUSH     = 3'd4;
    localparam logic [2:0] S_NEXT     = 3'd5;
    localparam logic [2:0] S_DRAIN    = 3'd6;
    localparam logic [2:0] S_FIN      = 3'd7;

    logic [2:0]          state;
    logic [RW-1:0]       r0_start_q;
    logic [RW-1:0]       r0_step_q;
    logic [7:0]          num_depths_q;
    logic [7:0]          num_angles_q;
    logic [DW_ANGLE-1:0] angle_step_q;
    logic [EW-1:0]       elem_q;
    logic                last_q;
    logic                last_point_q;
    logic                out_valid_q;
    logic                abort_q;
    logic                drain_ack_q;

    logic abort_any;
    logic res_last;
    logic last_depth;
    logic last_angle;

    // abort takes effect in the same cycle it is raised, then stays sticky
    assign abort_any  = abort_q | abort;
    assign res_last   = calc_last_element | (elem_q == EW'(NPAIR - 1));
    assign last_depth = (out_depth_idx == num_depths_q - 8'd1);
    assign last_angle = (out_angle_idx == num_angles_q - 8'd1);

    assign calc_initiate  = (state == S_ISSUE);
    assign calc_ack       = (state == S_ACK) | ((state == S_DRAIN) & drain_ack_q);
    assign busy           = (state != S_IDLE);
    assign done           = (state == S_FIN);
    assign out_valid      = out_valid_q;
    assign out_last_point = out_valid_q & last_point_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            r0_start_q    <= '0;
            r0_step_q     <= '0;
            num_depths_q  <= '0;
            num_angles_q  <= '0;
            angle_step_q  <= '0;
            calc_r0       <= '0;
            calc_angle    <= '0;
            elem_q        <= '0;
            out_element   <= '0;
            out_term_pos  <= '0;
            out_term_neg  <= '0;
            out_angle_idx <= '0;
            out_depth_idx <= '0;
            last_q        <= 1'b0;
            last_point_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            abort_q       <= 1'b0;
            drain_ack_q   <= 1'b0;
        end else begin
            if (state != S_IDLE && abort) begin
                abort_q <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        r0_start_q    <= cfg_r0_start;
                        r0_step_q     <= cfg_r0_step;
                        num_depths_q  <= cfg_num_depths;
                        num_angles_q  <= cfg_num_angles;
                        angle_step_q  <= cfg_angle_step;
                        calc_r0       <= cfg_r0_start;
                        calc_angle    <= cfg_angle_start;
                        out_angle_idx <= '0;
                        out_depth_idx <= '0;
                        elem_q        <= '0;
                        abort_q       <= 1'b0;
                        drain_ack_q   <= 1'b0;
                        if (cfg_num_angles == 8'd0 || cfg_num_depths == 8'd0) begin
                            state <= S_FIN;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= abort_any ? S_DRAIN : S_WAIT_RES;
                end
                S_WAIT_RES: begin
                    if (abort_any) begin
                        state <= S_DRAIN;
                    end else if (calc_ready) begin
                        out_term_pos <= calc_term_pos;
                        out_term_neg <= calc_term_neg;
                        out_element  <= elem_q;
                        last_q       <= res_last;
                        last_point_q <= res_last & last_depth & last_angle;
                        state        <= S_ACK;
                    end
                end
                S_ACK, S_PUSH: begin
                    // an abort drops the held result; the calculator still owes the rest of the point
                    if (abort_any) begin
                        out_valid_q <= 1'b0;
                        elem_q      <= elem_q + EW'(1);
                        state       <= last_q ? S_IDLE : S_DRAIN;
                    end else if (state == S_ACK) begin
                        out_valid_q <= 1'b1;
                        state       <= S_PUSH;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (last_q) begin
                            state <= S_NEXT;
                        end else begin
                            elem_q <= elem_q + EW'(1);
                            state  <= S_WAIT_RES;
                        end
                    end
                end
                S_NEXT: begin
                    elem_q <= '0;
                    if (abort_any) begin
                        state <= S_IDLE;
                    end else if (last_depth && last_angle) begin
                        state <= S_FIN;
                    end else begin
                        state <= S_ISSUE;
                        if (last_depth) begin
                            out_depth_idx <= '0;
                            calc_r0       <= r0_start_q;
                            out_angle_idx <= out_angle_idx + 8'd1;
                            calc_angle    <= calc_angle + angle_step_q;
                        end else begin
                            out_depth_idx <= out_depth_idx + 8'd1;
                            calc_r0       <= calc_r0 + r0_step_q;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_ack_q) begin
                        drain_ack_q <= 1'b0;
                        if (last_q) begin
                            state <= S_IDLE;
                        end
                    end else if (calc_ready) begin
                        drain_ack_q <= 1'b1;
                        last_q      <= res_last;
                        elem_q      <= elem_q + EW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
